// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle control sequencer for the 4-register/tmp/ALU datapath
module datapath_ctrl #(
    parameter int ALU_LAT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       ready,
    output logic       done,
    output logic       w,
    output logic [1:0] Rn,
    output logic [2:0] sr,
    output logic [2:0] bsel,
    output logic [2:0] tsel,
    output logic       lt,
    output logic [1:0] aluop
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_SHL  = 2'b11;

    localparam logic [1:0] ALUOP_SHL = 2'b10;

    // One-hot encodings for the write-source and tmp-source selects
    localparam logic [2:0] SR_IN    = 3'b001;
    localparam logic [2:0] SR_TMP   = 3'b100;
    localparam logic [2:0] TSEL_ALU = 3'b001;
    localparam logic [2:0] TSEL_BIN = 3'b100;

    // A WAIT cycle ahead of each EX covers a registered ALU result
    localparam bit USE_WAIT = (ALU_LAT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDT,
        S_WAIT,
        S_EX,
        S_WB
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [1:0] op_q;
    logic [1:0] rd_q;
    logic [1:0] rs_q;
    logic [1:0] imm_q;
    logic [1:0] cnt_q;
    logic       wb_seen_q;

    logic       accept;
    logic [2:0] ex_bsel;
    logic [1:0] ex_aluop;

    // R0 has no B-path select; it reads as zero through an all-off bsel
    function automatic logic [2:0] map_b(input logic [1:0] r);
        logic [2:0] m;
        case (r)
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b010;
            2'd3:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    assign accept = (state == S_IDLE) && instr_valid;

    // WAIT and EX share operand selects so the ALU sees stable inputs across both
    assign ex_bsel  = (op_q == OP_ALU) ? map_b(rs_q) : 3'b000;
    assign ex_aluop = (op_q == OP_SHL) ? ALUOP_SHL : ((op_q == OP_ALU) ? imm_q : 2'b00);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Instruction fields latched on acceptance; shift counter counts down per EX
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= 2'b00;
            rd_q  <= 2'b00;
            rs_q  <= 2'b00;
            imm_q <= 2'b00;
            cnt_q <= 2'b00;
        end else if (accept) begin
            op_q  <= instr[7:6];
            rd_q  <= instr[5:4];
            rs_q  <= instr[3:2];
            imm_q <= instr[1:0];
            cnt_q <= instr[1:0];
        end else if (state == S_EX && cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
        end
    end

    // Remembers that the previous cycle was write-back, so IDLE can flag done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_seen_q <= 1'b0;
        end else begin
            wb_seen_q <= (state == S_WB);
        end
    end

    // Next-state sequencing through load-tmp, optional wait, execute and write-back
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    next_state = (instr[7:6] == OP_LOAD) ? S_WB : S_LDT;
                end
            end
            S_LDT: begin
                if (op_q == OP_MOV) begin
                    next_state = S_WB;
                end else begin
                    next_state = USE_WAIT ? S_WAIT : S_EX;
                end
            end
            S_WAIT: begin
                next_state = S_EX;
            end
            S_EX: begin
                if (op_q == OP_SHL && cnt_q != 2'd0) begin
                    next_state = USE_WAIT ? S_WAIT : S_EX;
                end else begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Moore output decode from state and latched fields
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        w     = 1'b0;
        Rn    = 2'b00;
        sr    = 3'b000;
        bsel  = 3'b000;
        tsel  = 3'b000;
        lt    = 1'b0;
        aluop = 2'b00;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                done  = wb_seen_q;
            end
            S_LDT: begin
                bsel = (op_q == OP_MOV) ? map_b(rs_q) : map_b(rd_q);
                tsel = TSEL_BIN;
                lt   = 1'b1;
            end
            S_WAIT: begin
                bsel  = ex_bsel;
                aluop = ex_aluop;
            end
            S_EX: begin
                bsel  = ex_bsel;
                aluop = ex_aluop;
                tsel  = TSEL_ALU;
                lt    = 1'b1;
            end
            S_WB: begin
                w  = 1'b1;
                Rn = rd_q;
                sr = (op_q == OP_LOAD) ? SR_IN : SR_TMP;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - directed self-checking bench for datapath_ctrl
module tb_datapath_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] instr;
    logic       iv0;
    logic       iv1;

    logic       ready0, done0, w0, lt0;
    logic [1:0] rn0, aluop0;
    logic [2:0] sr0, bsel0, tsel0;
    logic       ready1, done1, w1, lt1;
    logic [1:0] rn1, aluop1;
    logic [2:0] sr1, bsel1, tsel1;

    logic [16:0] o0;
    logic [16:0] o1;
    logic [16:0] e;
    int          checks;
    int          failures;

    assign o0 = {ready0, done0, w0, rn0, sr0, bsel0, tsel0, lt0, aluop0};
    assign o1 = {ready1, done1, w1, rn1, sr1, bsel1, tsel1, lt1, aluop1};

    datapath_ctrl #(.ALU_LAT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(iv0),
        .ready(ready0), .done(done0), .w(w0), .Rn(rn0), .sr(sr0),
        .bsel(bsel0), .tsel(tsel0), .lt(lt0), .aluop(aluop0)
    );

    datapath_ctrl #(.ALU_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(iv1),
        .ready(ready1), .done(done1), .w(w1), .Rn(rn1), .sr(sr1),
        .bsel(bsel1), .tsel(tsel1), .lt(lt1), .aluop(aluop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] pk(input logic r, input logic d, input logic wr,
                                       input logic [1:0] rn, input logic [2:0] s,
                                       input logic [2:0] b, input logic [2:0] t,
                                       input logic l, input logic [1:0] a);
        return {r, d, wr, rn, s, b, t, l, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue0(input logic [7:0] i);
        instr = i; iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
    endtask

    task automatic issue1(input logic [7:0] i);
        instr = i; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; iv0 = 1'b0; iv1 = 1'b0; instr = 8'h00;
        tick(); tick();
        e = pk(1,0,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL reset_held0 got=%h exp=%h", o0, e); end
        checks++; if (o1 !== e) begin failures++; $display("FAIL reset_held1 got=%h exp=%h", o1, e); end
        reset_n = 1'b1;
        tick();
        checks++; if (o0 !== e) begin failures++; $display("FAIL reset_rel0 got=%h exp=%h", o0, e); end
        checks++; if (o1 !== e) begin failures++; $display("FAIL reset_rel1 got=%h exp=%h", o1, e); end
    endtask

    task automatic test_load();
        issue0(8'b00_10_0000);
        e = pk(0,0,1,2'd2,3'b001,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL load_wb got=%h exp=%h", o0, e); end
        tick();
        e = pk(1,1,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL load_done got=%h exp=%h", o0, e); end
        tick();
        e = pk(1,0,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL load_idle got=%h exp=%h", o0, e); end
    endtask

    task automatic test_alu();
        issue0(8'b10_01_11_00);
        e = pk(0,0,0,2'd0,3'b000,3'b001,3'b100,1,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL alu_ldt got=%h exp=%h", o0, e); end
        tick();
        e = pk(0,0,0,2'd0,3'b000,3'b100,3'b001,1,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL alu_ex got=%h exp=%h", o0, e); end
        tick();
        e = pk(0,0,1,2'd1,3'b100,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL alu_wb got=%h exp=%h", o0, e); end
        tick();
        e = pk(1,1,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL alu_done got=%h exp=%h", o0, e); end
        tick();
    endtask

    task automatic test_shl();
        issue0(8'b11_11_00_11);
        e = pk(0,0,0,2'd0,3'b000,3'b100,3'b100,1,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL shl3_ldt got=%h exp=%h", o0, e); end
        for (int i = 0; i < 4; i++) begin
            tick();
            e = pk(0,0,0,2'd0,3'b000,3'b000,3'b001,1,2'b10);
            checks++; if (o0 !== e) begin failures++; $display("FAIL shl3_ex%0d got=%h exp=%h", i, o0, e); end
        end
        tick();
        e = pk(0,0,1,2'd3,3'b100,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL shl3_wb got=%h exp=%h", o0, e); end
        tick();
        e = pk(1,1,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL shl3_done got=%h exp=%h", o0, e); end
        tick();
        issue0(8'b11_10_00_00);
        e = pk(0,0,0,2'd0,3'b000,3'b010,3'b100,1,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL shl0_ldt got=%h exp=%h", o0, e); end
        tick();
        e = pk(0,0,0,2'd0,3'b000,3'b000,3'b001,1,2'b10);
        checks++; if (o0 !== e) begin failures++; $display("FAIL shl0_ex got=%h exp=%h", o0, e); end
        tick();
        e = pk(0,0,1,2'd2,3'b100,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL shl0_wb got=%h exp=%h", o0, e); end
        tick();
        e = pk(1,1,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL shl0_done got=%h exp=%h", o0, e); end
        tick();
    endtask

    task automatic test_alu_lat1();
        issue1(8'b10_01_11_00);
        e = pk(0,0,0,2'd0,3'b000,3'b001,3'b100,1,2'b00);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_ldt got=%h exp=%h", o1, e); end
        tick();
        e = pk(0,0,0,2'd0,3'b000,3'b100,3'b000,0,2'b00);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_wait got=%h exp=%h", o1, e); end
        tick();
        e = pk(0,0,0,2'd0,3'b000,3'b100,3'b001,1,2'b00);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_ex got=%h exp=%h", o1, e); end
        tick();
        e = pk(0,0,1,2'd1,3'b100,3'b000,3'b000,0,2'b00);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_wb got=%h exp=%h", o1, e); end
        tick();
        e = pk(1,1,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_done got=%h exp=%h", o1, e); end
        tick();
        issue1(8'b10_10_01_01);
        tick();
        e = pk(0,0,0,2'd0,3'b000,3'b001,3'b000,0,2'b01);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_and_wait got=%h exp=%h", o1, e); end
        tick();
        e = pk(0,0,0,2'd0,3'b000,3'b001,3'b001,1,2'b01);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_and_ex got=%h exp=%h", o1, e); end
        tick(); tick();
        issue1(8'b11_01_00_01);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = pk(0,0,0,2'd0,3'b000,3'b000,3'b000,0,2'b10);
            checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_shl_wait%0d got=%h exp=%h", i, o1, e); end
            tick();
            e = pk(0,0,0,2'd0,3'b000,3'b000,3'b001,1,2'b10);
            checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_shl_ex%0d got=%h exp=%h", i, o1, e); end
        end
        tick();
        e = pk(0,0,1,2'd1,3'b100,3'b000,3'b000,0,2'b00);
        checks++; if (o1 !== e) begin failures++; $display("FAIL lat1_shl_wb got=%h exp=%h", o1, e); end
        tick(); tick();
    endtask

    task automatic test_handshake();
        instr = 8'b01_01_10_00; iv0 = 1'b1;
        tick();
        e = pk(0,0,0,2'd0,3'b000,3'b010,3'b100,1,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL hs_mov_ldt got=%h exp=%h", o0, e); end
        instr = 8'b11_00_00_11;
        tick();
        e = pk(0,0,1,2'd1,3'b100,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL hs_mov_wb got=%h exp=%h", o0, e); end
        instr = 8'b00_11_0101;
        tick();
        e = pk(1,1,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL hs_done got=%h exp=%h", o0, e); end
        tick();
        iv0 = 1'b0;
        e = pk(0,0,1,2'd3,3'b001,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL hs_b2b_wb got=%h exp=%h", o0, e); end
        tick();
        e = pk(1,1,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL hs_b2b_done got=%h exp=%h", o0, e); end
        tick();
    endtask

    task automatic test_reset_midop();
        issue0(8'b11_11_00_11);
        tick(); tick();
        e = pk(0,0,0,2'd0,3'b000,3'b000,3'b001,1,2'b10);
        checks++; if (o0 !== e) begin failures++; $display("FAIL rst_pre_ex2 got=%h exp=%h", o0, e); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (lt0 !== 1'b0 || w0 !== 1'b0) begin failures++; $display("FAIL rst_async_strobes got=lt%b_w%b exp=lt0_w0", lt0, w0); end
        e = pk(1,0,0,2'd0,3'b000,3'b000,3'b000,0,2'b00);
        checks++; if (o0 !== e) begin failures++; $display("FAIL rst_async_idle got=%h exp=%h", o0, e); end
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o0 !== e) begin failures++; $display("FAIL rst_after%0d got=%h exp=%h", i, o0, e); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_load();
        test_alu();
        test_shl();
        test_alu_lat1();
        test_handshake();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
